// File: rtl/uart_pkg.sv
// Shared UART definitions: rx FSM encoding, parity mode constants, default geometry.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_e;

  localparam logic PAR_ODD  = 1'b0;
  localparam logic PAR_EVEN = 1'b1;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_OVERSAMPLE = 16;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for an asynchronous level input (rx line, CTS).
module uart_rx_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta <= RST_VAL;
      q_o  <= RST_VAL;
    end else begin
      meta <= d_i;
      q_o  <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_deframer.sv
// UART receive deframer: mid-bit sampling on an oversampling tick, LSB-first
// deserialisation, optional parity and stop checks, valid/ready word output.
module uart_rx_deframer
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int OVERSAMPLE = DEF_OVERSAMPLE
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  baud_tick_i,
  input  logic                  rx_i,
  input  logic                  parity_en_i,
  input  logic                  parity_mode_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic                  parity_err_o,
  output logic                  frame_err_o,
  output logic                  overrun_err_o,
  output logic                  busy_o
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int IW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] HALF_LAST = CW'(OVERSAMPLE/2 - 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(OVERSAMPLE - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_WIDTH - 1);

  rx_state_e             state;
  logic                  rxs;
  logic [CW-1:0]         cnt;
  logic [IW-1:0]         bit_idx;
  logic [DATA_WIDTH-1:0] shreg;
  logic                  par_acc;
  logic                  par_en_q;
  logic                  par_mode_q;
  logic                  par_err_q;

  uart_rx_sync #(.RST_VAL(1'b1)) u_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (rx_i),
    .q_o   (rxs)
  );

  assign busy_o = (state != ST_IDLE);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      bit_idx       <= '0;
      shreg         <= '0;
      par_acc       <= 1'b0;
      par_en_q      <= 1'b0;
      par_mode_q    <= PAR_ODD;
      par_err_q     <= 1'b0;
      data_o        <= '0;
      valid_o       <= 1'b0;
      parity_err_o  <= 1'b0;
      frame_err_o   <= 1'b0;
      overrun_err_o <= 1'b0;
    end else begin
      // Acceptance first; a word completing on the same edge re-asserts valid.
      if (valid_o && ready_i) valid_o <= 1'b0;

      if (baud_tick_i) begin
        case (state)
          ST_IDLE: begin
            if (!rxs) begin
              state <= ST_START;
              cnt   <= '0;
            end
          end
          ST_START: begin
            if (cnt == HALF_LAST) begin
              cnt <= '0;
              if (rxs) begin
                state <= ST_IDLE;
              end else begin
                state      <= ST_DATA;
                bit_idx    <= '0;
                par_acc    <= 1'b0;
                par_err_q  <= 1'b0;
                par_en_q   <= parity_en_i;
                par_mode_q <= parity_mode_i;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          ST_DATA: begin
            if (cnt == FULL_LAST) begin
              cnt     <= '0;
              shreg   <= {rxs, shreg[DATA_WIDTH-1:1]};
              par_acc <= par_acc ^ rxs;
              if (bit_idx == IDX_LAST) state <= par_en_q ? ST_PARITY : ST_STOP;
              else                     bit_idx <= bit_idx + 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          ST_PARITY: begin
            if (cnt == FULL_LAST) begin
              cnt       <= '0;
              par_err_q <= rxs != ((par_mode_q == PAR_EVEN) ? par_acc : ~par_acc);
              state     <= ST_STOP;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          ST_STOP: begin
            if (cnt == FULL_LAST) begin
              cnt          <= '0;
              state        <= ST_IDLE;
              data_o       <= shreg;
              parity_err_o <= par_en_q & par_err_q;
              frame_err_o  <= ~rxs;
              valid_o      <= 1'b1;
              if (valid_o && !ready_i) overrun_err_o <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Directed bench for uart_rx_deframer: 8N1/8E1/8O1 frames, glitch, framing
// error, overrun and mid-frame reset.
module tb_uart_rx_deframer;

  localparam int DW = 8;
  localparam int OS = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          tick = 1'b0;
  logic          rx = 1'b1;
  logic          par_en = 1'b0;
  logic          par_mode = 1'b0;
  logic          ready = 1'b0;
  logic [DW-1:0] data;
  logic          valid, pe, fe, oe, busy;

  int n_tests = 0;
  int n_fail  = 0;

  uart_rx_deframer #(.DATA_WIDTH(DW), .OVERSAMPLE(OS)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .baud_tick_i   (tick),
    .rx_i          (rx),
    .parity_en_i   (par_en),
    .parity_mode_i (par_mode),
    .data_o        (data),
    .valid_o       (valid),
    .ready_i       (ready),
    .parity_err_o  (pe),
    .frame_err_o   (fe),
    .overrun_err_o (oe),
    .busy_o        (busy)
  );

  always #5 clk = ~clk;

  // One tick every 4 clocks.
  initial begin
    forever begin
      repeat (3) @(posedge clk);
      #1 tick = 1'b1;
      @(posedge clk);
      #1 tick = 1'b0;
    end
  end

  initial begin
    #20ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_ticks(input int n);
    int k = 0;
    while (k < n) begin
      @(posedge clk);
      if (tick) k++;
    end
  endtask

  task automatic send_bit(input logic b);
    #1 rx = b;
    wait_ticks(OS);
  endtask

  task automatic idle(input int n);
    #1 rx = 1'b1;
    wait_ticks(n);
  endtask

  task automatic send_frame(input logic [DW-1:0] d, input logic with_par,
                            input logic pbit, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < DW; i++) send_bit(d[i]);
    if (with_par) send_bit(pbit);
    send_bit(stop);
  endtask

  task automatic wait_valid(input string tag);
    int c = 0;
    @(negedge clk);
    while (!valid && c < 200) begin
      @(negedge clk);
      c++;
    end
    chk(tag, {31'd0, valid}, 32'd1);
  endtask

  task automatic accept(input string tag);
    @(negedge clk);
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    chk(tag, {31'd0, valid}, 32'd0);
  endtask

  initial begin
    int seen;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_data",  {24'd0, data}, 32'h0);
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_flags", {29'd0, pe, fe, oe}, 32'd0);
    chk("rst_busy",  {31'd0, busy}, 32'd0);
    rst = 1'b0;
    idle(4);

    // 8N1 0xA5
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
    idle(2);
    wait_valid("a5_valid");
    chk("a5_data",  {24'd0, data}, 32'hA5);
    chk("a5_flags", {29'd0, pe, fe, oe}, 32'd0);
    chk("a5_busy",  {31'd0, busy}, 32'd0);
    accept("a5_drop");

    // 8E1
    par_en = 1'b1; par_mode = 1'b1;
    send_frame(8'h03, 1'b1, 1'b0, 1'b1);
    idle(2);
    wait_valid("e03_valid");
    chk("e03_data", {24'd0, data}, 32'h03);
    chk("e03_pe",   {31'd0, pe}, 32'd0);
    accept("e03_drop");
    send_frame(8'h03, 1'b1, 1'b1, 1'b1);
    idle(2);
    wait_valid("e03b_valid");
    chk("e03b_pe", {31'd0, pe}, 32'd1);
    accept("e03b_drop");

    // 8O1
    par_mode = 1'b0;
    send_frame(8'h07, 1'b1, 1'b0, 1'b1);
    idle(2);
    wait_valid("o07_valid");
    chk("o07_data", {24'd0, data}, 32'h07);
    chk("o07_pe",   {31'd0, pe}, 32'd0);
    accept("o07_drop");
    send_frame(8'h00, 1'b1, 1'b0, 1'b1);
    idle(2);
    wait_valid("o00_valid");
    chk("o00_pe", {31'd0, pe}, 32'd1);
    accept("o00_drop");
    par_en = 1'b0;

    // Start-bit glitch: 5 ticks low
    #1 rx = 1'b0;
    wait_ticks(3);
    @(negedge clk);
    chk("glitch_busy", {31'd0, busy}, 32'd1);
    wait_ticks(2);
    idle(14);
    @(negedge clk);
    chk("glitch_idle",  {31'd0, busy}, 32'd0);
    chk("glitch_valid", {31'd0, valid}, 32'd0);

    // Framing error
    send_frame(8'h55, 1'b0, 1'b0, 1'b0);
    idle(20);
    wait_valid("fe_valid");
    chk("fe_data", {24'd0, data}, 32'h55);
    chk("fe_flag", {31'd0, fe}, 32'd1);
    chk("fe_pe",   {31'd0, pe}, 32'd0);
    chk("fe_busy", {31'd0, busy}, 32'd0);
    accept("fe_drop");

    // Overrun
    send_frame(8'h11, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    chk("ov1_valid", {31'd0, valid}, 32'd1);
    chk("ov1_oe",    {31'd0, oe}, 32'd0);
    send_frame(8'h22, 1'b0, 1'b0, 1'b1);
    idle(2);
    @(negedge clk);
    chk("ov2_valid", {31'd0, valid}, 32'd1);
    chk("ov2_data",  {24'd0, data}, 32'h22);
    chk("ov2_oe",    {31'd0, oe}, 32'd1);
    chk("ov2_fe",    {31'd0, fe}, 32'd0);

    // Reset during a third frame
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("mrst_out", {24'd0, data}, 32'h0);
    chk("mrst_flags", {27'd0, valid, pe, fe, oe, busy}, 32'd0);
    #1 rst = 1'b0;
    for (int i = 0; i < DW; i++) send_bit(1'b1);
    seen = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (valid) seen = 1;
    end
    chk("mrst_no_valid", seen, 32'd0);
    chk("mrst_oe", {31'd0, oe}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
